// File: rtl/breakout_game_ctrl.sv
// Breakout game sequencer: tracks lives and score and steps through
// idle/serve/play/miss/over/win phases on the 75 Hz frame tick.
module breakout_game_ctrl #(
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 75,
  parameter int MISS_FRAMES  = 38,
  parameter int END_FRAMES   = 225
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_tick75hz,
  input  logic        i_btn_start,
  input  logic        i_ball_miss,
  input  logic        i_brick_hit,
  input  logic [7:0]  i_bricks_left,
  output logic        o_paddle_en,
  output logic        o_ball_reset,
  output logic        o_ball_launch,
  output logic [1:0]  o_lives,
  output logic [15:0] o_score,
  output logic [2:0]  o_state,
  output logic        o_game_over,
  output logic        o_win
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_MISS  = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;
  localparam logic [2:0] ST_WIN   = 3'd5;

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [7:0] SERVE_T    = 8'(SERVE_FRAMES);
  localparam logic [7:0] MISS_T     = 8'(MISS_FRAMES);
  localparam logic [7:0] END_T      = 8'(END_FRAMES);

  logic [2:0]  r_state;
  logic [1:0]  r_lives;
  logic [15:0] r_score;
  logic [7:0]  r_timer;
  logic        r_start_q;
  logic        r_launch;

  logic w_start_rise;
  logic w_last_tick;

  assign w_start_rise = i_btn_start & ~r_start_q;
  assign w_last_tick  = i_tick75hz && (r_timer == 8'd1);

  // start_q resets high so a button held through reset cannot start a game
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_lives   <= 2'd0;
      r_score   <= 16'd0;
      r_timer   <= 8'd0;
      r_start_q <= 1'b1;
      r_launch  <= 1'b0;
    end else begin
      r_start_q <= i_btn_start;
      r_launch  <= 1'b0;
      if (r_state == ST_PLAY && i_brick_hit && r_score != 16'hFFFF)
        r_score <= r_score + 16'd1;
      case (r_state)
        ST_IDLE: begin
          if (w_start_rise) begin
            r_state <= ST_SERVE;
            r_lives <= LIVES_INIT;
            r_score <= 16'd0;
            r_timer <= SERVE_T;
          end
        end
        ST_SERVE: begin
          if (i_tick75hz) begin
            r_timer <= r_timer - 8'd1;
            if (w_last_tick) begin
              r_state  <= ST_PLAY;
              r_launch <= 1'b1;
            end
          end
        end
        ST_PLAY: begin
          // board clear outranks a simultaneous miss
          if (i_bricks_left == 8'd0) begin
            r_state <= ST_WIN;
            r_timer <= END_T;
          end else if (i_ball_miss) begin
            r_state <= ST_MISS;
            r_lives <= r_lives - 2'd1;
            r_timer <= MISS_T;
          end
        end
        ST_MISS: begin
          if (i_tick75hz) begin
            if (w_last_tick) begin
              if (r_lives == 2'd0) begin
                r_state <= ST_OVER;
                r_timer <= END_T;
              end else begin
                r_state <= ST_SERVE;
                r_timer <= SERVE_T;
              end
            end else begin
              r_timer <= r_timer - 8'd1;
            end
          end
        end
        ST_OVER, ST_WIN: begin
          if (i_tick75hz) begin
            r_timer <= r_timer - 8'd1;
            if (w_last_tick) r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_paddle_en   = (r_state == ST_SERVE) || (r_state == ST_PLAY);
  assign o_ball_reset  = (r_state == ST_IDLE) || (r_state == ST_SERVE) ||
                         (r_state == ST_MISS) || (r_state == ST_OVER) ||
                         (r_state == ST_WIN);
  assign o_game_over   = (r_state == ST_OVER);
  assign o_win         = (r_state == ST_WIN);
  assign o_ball_launch = r_launch;
  assign o_lives       = r_lives;
  assign o_score       = r_score;
  assign o_state       = r_state;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Bench for breakout_game_ctrl: scenario tasks with randomized tick spacing
// and hit patterns, expectations from tick counts and a running score tally.
module tb_breakout_game_ctrl;

  localparam int LIVES = 3, SERVE_FRAMES = 75, MISS_FRAMES = 38, END_FRAMES = 225;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick, btn, miss, hit;
  logic [7:0]  bricks;
  logic        paddle_en, ball_reset, ball_launch, game_over, win;
  logic [1:0]  lives;
  logic [15:0] score;
  logic [2:0]  state;

  int checks = 0;
  int failures = 0;
  int exp_score = 0;
  int exp_lives = 0;

  breakout_game_ctrl #(
    .LIVES(LIVES), .SERVE_FRAMES(SERVE_FRAMES),
    .MISS_FRAMES(MISS_FRAMES), .END_FRAMES(END_FRAMES)
  ) dut (
    .clk(clk), .reset(reset), .i_tick75hz(tick), .i_btn_start(btn),
    .i_ball_miss(miss), .i_brick_hit(hit), .i_bricks_left(bricks),
    .o_paddle_en(paddle_en), .o_ball_reset(ball_reset), .o_ball_launch(ball_launch),
    .o_lives(lives), .o_score(score), .o_state(state),
    .o_game_over(game_over), .o_win(win)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) step();
  endtask

  // press start from IDLE and walk SERVE to PLAY with randomly spaced ticks
  task automatic new_game_to_play();
    btn = 1'b0; step();
    btn = 1'b1; step();
    btn = 1'b0;
    exp_score = 0; exp_lives = LIVES;
    for (int i = 0; i < SERVE_FRAMES; i++) begin
      tick = 1'b1; step(); tick = 1'b0; gap();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; btn = 1'b1; tick = 1'b0; miss = 1'b0; hit = 1'b0; bricks = 8'd50;
    repeat (3) step();
    reset = 1'b0;
    step(); step();
    checks++;
    if (state !== 3'd0 || lives !== 2'd0 || score !== 16'd0 || paddle_en !== 1'b0 ||
        ball_reset !== 1'b1 || game_over !== 1'b0 || win !== 1'b0 || ball_launch !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: state=%0d lives=%0d score=%0d pad=%b brst=%b go=%b win=%b launch=%b required 0/0/0/0/1/0/0/0",
               state, lives, score, paddle_en, ball_reset, game_over, win, ball_launch);
    end
    btn = 1'b0; step();
    btn = 1'b1; step();
    checks++;
    if (state !== 3'd1 || lives !== 2'd3 || score !== 16'd0) begin
      failures++;
      $display("FAIL start_press: state=%0d lives=%0d score=%0d required 1/3/0", state, lives, score);
    end
    btn = 1'b0;
  endtask

  task automatic test_serve();
    for (int i = 0; i < SERVE_FRAMES; i++) begin
      tick = 1'b1; step(); tick = 1'b0;
      if (i < SERVE_FRAMES - 1) begin
        checks++;
        if (state !== 3'd1 || paddle_en !== 1'b1 || ball_launch !== 1'b0) begin
          failures++;
          $display("FAIL serve_hold tick %0d: state=%0d pad=%b launch=%b required 1/1/0", i + 1, state, paddle_en, ball_launch);
        end
        gap();
      end
    end
    checks++;
    if (state !== 3'd2 || ball_launch !== 1'b1 || paddle_en !== 1'b1 || ball_reset !== 1'b0) begin
      failures++;
      $display("FAIL serve_exit: state=%0d launch=%b pad=%b brst=%b required 2/1/1/0", state, ball_launch, paddle_en, ball_reset);
    end
    step();
    checks++;
    if (state !== 3'd2 || ball_launch !== 1'b0) begin
      failures++;
      $display("FAIL launch_pulse: state=%0d launch=%b required 2/0", state, ball_launch);
    end
    // frame ticks are not counted in PLAY
    for (int i = 0; i < 4; i++) begin
      tick = 1'b1; step(); tick = 1'b0;
    end
    checks++;
    if (state !== 3'd2) begin
      failures++;
      $display("FAIL play_ignores_tick: state=%0d required 2", state);
    end
  endtask

  task automatic test_score_miss();
    exp_score = 0; exp_lives = LIVES;
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) step();
      hit = 1'b1; step(); hit = 1'b0;
      exp_score++;
      checks++;
      if (score !== 16'(exp_score)) begin
        failures++;
        $display("FAIL score_hit %0d: score=%0d required %0d", i, score, exp_score);
      end
    end
    hit = 1'b1; miss = 1'b1; step(); hit = 1'b0; miss = 1'b0;
    exp_score++; exp_lives--;
    checks++;
    if (state !== 3'd3 || lives !== 2'(exp_lives) || score !== 16'd5 || paddle_en !== 1'b0 || ball_reset !== 1'b1) begin
      failures++;
      $display("FAIL hit_and_miss: state=%0d lives=%0d score=%0d pad=%b brst=%b required 3/%0d/5/0/1",
               state, lives, score, paddle_en, ball_reset, exp_lives);
    end
    hit = 1'b1; miss = 1'b1; step(); hit = 1'b0; miss = 1'b0;
    checks++;
    if (score !== 16'd5 || lives !== 2'(exp_lives) || state !== 3'd3) begin
      failures++;
      $display("FAIL hit_in_miss: score=%0d lives=%0d state=%0d required 5/%0d/3", score, lives, state, exp_lives);
    end
  endtask

  task automatic test_game_over();
    bit good;
    // two more round trips MISS -> SERVE -> PLAY -> MISS, then final expiry
    while (exp_lives >= 0) begin
      good = 1'b1;
      for (int i = 0; i < MISS_FRAMES; i++) begin
        tick = 1'b1; step(); tick = 1'b0;
        if (i < MISS_FRAMES - 1) begin
          if (state !== 3'd3) good = 1'b0;
          gap();
        end
      end
      checks++;
      if (!good) begin
        failures++;
        $display("FAIL miss_hold lives=%0d: left MISS early, state=%0d", exp_lives, state);
      end
      if (exp_lives == 0) break;
      checks++;
      if (state !== 3'd1) begin
        failures++;
        $display("FAIL miss_to_serve lives=%0d: state=%0d required 1", exp_lives, state);
      end
      for (int i = 0; i < SERVE_FRAMES; i++) begin
        tick = 1'b1; step(); tick = 1'b0; gap();
      end
      repeat ($urandom_range(1, 5)) step();
      miss = 1'b1; step(); miss = 1'b0;
      exp_lives--;
      checks++;
      if (state !== 3'd3 || lives !== 2'(exp_lives)) begin
        failures++;
        $display("FAIL replay_miss: state=%0d lives=%0d required 3/%0d", state, lives, exp_lives);
      end
    end
    checks++;
    if (state !== 3'd4 || game_over !== 1'b1 || win !== 1'b0 || ball_reset !== 1'b1 || lives !== 2'd0) begin
      failures++;
      $display("FAIL over_entry: state=%0d go=%b win=%b brst=%b lives=%0d required 4/1/0/1/0",
               state, game_over, win, ball_reset, lives);
    end
    good = 1'b1;
    for (int i = 0; i < END_FRAMES; i++) begin
      btn = (i % 7 == 3);
      hit = 1'b1;
      tick = 1'b1; step(); tick = 1'b0; hit = 1'b0;
      if (i < END_FRAMES - 1) begin
        if (state !== 3'd4 || score !== 16'd5) good = 1'b0;
        gap();
      end
    end
    btn = 1'b0;
    checks++;
    if (!good) begin
      failures++;
      $display("FAIL over_hold: left OVER early or score moved, state=%0d score=%0d", state, score);
    end
    checks++;
    if (state !== 3'd0 || game_over !== 1'b0) begin
      failures++;
      $display("FAIL over_exit: state=%0d go=%b required 0/0", state, game_over);
    end
  endtask

  task automatic test_win();
    new_game_to_play();
    checks++;
    if (state !== 3'd2 || score !== 16'd0 || lives !== 2'd3) begin
      failures++;
      $display("FAIL new_game: state=%0d score=%0d lives=%0d required 2/0/3", state, score, lives);
    end
    for (int i = 0; i < 24; i++) begin
      hit = 1'($urandom_range(0, 1));
      tick = 1'($urandom_range(0, 1));
      step();
      if (hit) exp_score++;
      hit = 1'b0; tick = 1'b0;
      checks++;
      if (score !== 16'(exp_score) || state !== 3'd2) begin
        failures++;
        $display("FAIL rand_score %0d: score=%0d state=%0d required %0d/2", i, score, state, exp_score);
      end
    end
    bricks = 8'd0; miss = 1'b1; hit = 1'b1; step();
    miss = 1'b0; hit = 1'b0; bricks = 8'd50;
    exp_score++;
    checks++;
    if (state !== 3'd5 || win !== 1'b1 || game_over !== 1'b0 || lives !== 2'd3 || score !== 16'(exp_score)) begin
      failures++;
      $display("FAIL win_priority: state=%0d win=%b go=%b lives=%0d score=%0d required 5/1/0/3/%0d",
               state, win, game_over, lives, score, exp_score);
    end
    for (int i = 0; i < END_FRAMES; i++) begin
      tick = 1'b1; step(); tick = 1'b0; gap();
    end
    checks++;
    if (state !== 3'd0 || win !== 1'b0) begin
      failures++;
      $display("FAIL win_exit: state=%0d win=%b required 0/0", state, win);
    end
  endtask

  task automatic test_async_reset();
    new_game_to_play();
    for (int i = 0; i < 12; i++) begin
      hit = 1'b1; step(); hit = 1'b0; gap();
    end
    checks++;
    if (score !== 16'd12 || state !== 3'd2) begin
      failures++;
      $display("FAIL pre_reset: score=%0d state=%0d required 12/2", score, state);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (state !== 3'd0 || score !== 16'd0 || lives !== 2'd0 || paddle_en !== 1'b0 || ball_reset !== 1'b1) begin
      failures++;
      $display("FAIL async_reset: state=%0d score=%0d lives=%0d pad=%b brst=%b required 0/0/0/0/1",
               state, score, lives, paddle_en, ball_reset);
    end
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_serve();
    test_score_miss();
    test_game_over();
    test_win();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/breakout_game_ctrl.md
# breakout_game_ctrl

Top-level game sequencer for the HDMI Breakout design. Tracks lives and score, and steps the game through idle, serve, play, miss, game-over and win phases using the 75 Hz frame tick. Drives the paddle-enable and ball-reset/launch controls consumed by the paddle and ball animation blocks, and reports status to the score/text overlay.

## Interface

- LIVES, 3: lives granted at game start; legal range 1..3.
- SERVE_FRAMES, 75: frame ticks spent in SERVE before launch; legal range 1..255.
- MISS_FRAMES, 38: frame ticks spent in MISS after a lost ball; legal range 1..255.
- END_FRAMES, 225: minimum frame ticks held in OVER/WIN before returning to IDLE; legal range 1..255.

- clk  in  1  pixel-domain system clock.
- reset  in  1  asynchronous, active-high reset.
- tick75hz  in  1  one-cycle frame-tick pulse.
- btn_start  in  1  start button, level, already synchronous to clk.
- ball_miss  in  1  one-cycle pulse; ball passed below the paddle.
- brick_hit  in  1  one-cycle pulse; one brick destroyed.
- bricks_left  in  8  count of remaining bricks.
- paddle_en  out  1  paddle may move.
- ball_reset  out  1  hold ball at its serve position.
- ball_launch  out  1  one-cycle pulse; release the ball.
- lives  out  2  remaining lives.
- score  out  16  bricks destroyed this game.
- state  out  3  current state code.
- game_over  out  1  high in OVER.
- win  out  1  high in WIN.

## Operation

- State codes: IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4, WIN=5. Codes 6 and 7 return to IDLE on the next clock.
- Internal registers: 8-bit frame timer and start_q, the previous btn_start value. start_rise = btn_start & ~start_q.
- Moore decodes from state:
  - paddle_en = 1 in SERVE and PLAY.
  - ball_reset = 1 in IDLE, SERVE, MISS, OVER and WIN.
  - game_over = 1 in OVER only.
  - win = 1 in WIN only.
- IDLE: on start_rise, go to SERVE. On the same edge, lives <= LIVES, score <= 0, timer <= SERVE_FRAMES.
- SERVE, MISS, OVER, WIN: each tick75hz decrements the timer. A tick that arrives with timer == 1 causes the exit transition on that edge.
  - SERVE exits to PLAY. ball_launch is registered high for exactly the first PLAY cycle.
  - MISS exits to OVER if lives == 0, loading timer <= END_FRAMES. Otherwise it exits to SERVE, loading timer <= SERVE_FRAMES.
  - OVER and WIN exit to IDLE. btn_start is ignored until the state is back in IDLE.
- PLAY, checked in this priority order:
  - If bricks_left == 0: go to WIN, timer <= END_FRAMES.
  - Else if ball_miss: go to MISS, lives <= lives - 1, timer <= MISS_FRAMES.
- score increments by 1 on brick_hit only while in PLAY, including a cycle that also exits PLAY. It saturates at 16'hFFFF.
- brick_hit and ball_miss are ignored in every state other than PLAY.
- lives never underflows, because MISS is entered only from PLAY with lives >= 1.

## Timing

- Reset values:
  - state=IDLE, lives=0, score=0, timer=0, ball_launch=0.
  - start_q=1, so a button held through reset does not start a game.
  - Resulting outputs: paddle_en=0, ball_reset=1, game_over=0, win=0.
- Reset asserted mid-game forces all of the above immediately, without waiting for a clock.
- Latency from start_rise to state=SERVE: 1 clk.
- SERVE lasts exactly SERVE_FRAMES ticks; PLAY is entered on the edge that samples the final tick.
- ball_miss to MISS, with lives decremented: 1 clk.
- bricks_left == 0 to WIN: 1 clk. This takes priority over a simultaneous ball_miss.
- tick75hz is not counted in IDLE or PLAY.

## Test plan

- Reset with btn_start held high → stays in IDLE. Release, then press → SERVE after 1 clk, with lives=3 and score=0.
- In SERVE with SERVE_FRAMES=75 → exactly 75 ticks later state=PLAY, ball_launch high for 1 clk only, and paddle_en=1 throughout SERVE and PLAY.
- In PLAY, pulse brick_hit 5 times, including once in the same cycle as ball_miss → score=5, state=MISS, lives=2. brick_hit pulsed during MISS leaves score at 5.
- Three misses → after the third MISS expiry, state=OVER with game_over=1. start_rise during the END_FRAMES hold is ignored. After 225 ticks, state=IDLE.
- In PLAY, drive bricks_left=0 and ball_miss in the same cycle → WIN with win=1 and lives unchanged.
- Assert reset asynchronously mid-PLAY with score=12 → without a clock edge, outputs show state=0, score=0, lives=0, paddle_en=0 and ball_reset=1.
